// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arb_pkg
//  Purpose  : Shared types and defaults for the data-memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int C_DEFAULT_AW = 8;
    localparam int C_DEFAULT_DW = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_SEL_CPU  = 1'b0,
        OWN_SEL_HOST = 1'b1
    } owner_e;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Round-robin, grant-holding arbiter between CPU and host for the
//             single-port data memory, with a bounded hold limit.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = C_DEFAULT_AW,
    parameter int DW       = C_DEFAULT_DW,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    input  logic          host_req,
    input  logic          host_wr,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            HW          = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] C_HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0] C_HOLD_SAT  = '1;

    arb_state_e    state_q, state_d;
    owner_e        last_owner_q, last_owner_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          cpu_rvalid_q, host_rvalid_q;
    logic          cpu_acc, host_acc;

    assign cpu_gnt  = (state_q == OWN_CPU);
    assign host_gnt = (state_q == OWN_HOST);
    assign cpu_acc  = cpu_gnt & cpu_req;
    assign host_acc = host_gnt & host_req;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr    = 1'b0;
        if (cpu_acc) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wr    = cpu_wr;
        end else if (host_acc) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_wr    = host_wr;
        end
    end

    // Masking with reset kills a read response whose access preceded reset.
    assign cpu_rvalid  = cpu_rvalid_q & ~reset;
    assign host_rvalid = host_rvalid_q & ~reset;
    assign rdata       = mem_rdata;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req && host_req)
                    state_d = (last_owner_q == OWN_SEL_HOST) ? OWN_CPU : OWN_HOST;
                else if (cpu_req)
                    state_d = OWN_CPU;
                else if (host_req)
                    state_d = OWN_HOST;
            end
            OWN_CPU: begin
                if (cpu_req) begin
                    if (host_req && (hold_cnt_q >= C_HOLD_LAST))
                        state_d = OWN_HOST;
                end else begin
                    state_d = host_req ? OWN_HOST : IDLE;
                end
            end
            OWN_HOST: begin
                if (host_req) begin
                    if (cpu_req && (hold_cnt_q >= C_HOLD_LAST))
                        state_d = OWN_CPU;
                end else begin
                    state_d = cpu_req ? OWN_CPU : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        if (state_d != state_q) begin
            hold_cnt_d = '0;
            if (state_d == OWN_CPU)
                last_owner_d = OWN_SEL_CPU;
            else if (state_d == OWN_HOST)
                last_owner_d = OWN_SEL_HOST;
        end else if ((cpu_acc || host_acc) && (hold_cnt_q != C_HOLD_SAT)) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_owner_q  <= OWN_SEL_HOST;
            hold_cnt_q    <= '0;
            cpu_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_owner_q  <= last_owner_d;
            hold_cnt_q    <= hold_cnt_d;
            cpu_rvalid_q  <= cpu_acc & ~cpu_wr;
            host_rvalid_q <= host_acc & ~host_wr;
        end
    end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Directed self-checking bench for dmem_arbiter with a RAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_wr, host_req, host_wr;
    logic [7:0]  cpu_addr, host_addr, mem_addr;
    logic [15:0] cpu_wdata, host_wdata, mem_wdata, mem_rdata, rdata;
    logic        cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, mem_wr;
    logic [15:0] ram [256];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.AW(8), .DW(16), .MAX_HOLD(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .host_req   (host_req),
        .host_wr    (host_wr),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rvalid(host_rvalid),
        .rdata      (rdata),
        .mem_addr   (mem_addr),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM, read data one cycle after the address.
    always @(posedge clk) begin
        if (mem_wr)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cpu_req = 1'b0;
        host_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        settle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            ram[i] = {8'hA5, 8'(i)};
        mem_rdata  = '0;
        cpu_wr     = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        host_wr    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        do_reset();

        // Reset state
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_host_gnt", host_gnt, 0);
        chk("rst_rvalid", {cpu_rvalid, host_rvalid}, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);

        // CPU alone: write BEEF to 0x10, then read it back
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h10; cpu_wdata = 16'hBEEF;
        settle();
        chk("t1_idle_no_gnt", cpu_gnt, 0);
        tick();
        chk("t1_cpu_gnt", cpu_gnt, 1);
        chk("t1_mem_wr", mem_wr, 1);
        chk("t1_mem_addr", mem_addr, 8'h10);
        chk("t1_mem_wdata", mem_wdata, 16'hBEEF);
        tick();
        cpu_wr = 1'b0; cpu_wdata = 16'h0;
        settle();
        chk("t1_rd_mem_wr", mem_wr, 0);
        chk("t1_rd_wdata_zero", mem_wdata, 0);
        tick();
        chk("t1_cpu_rvalid", cpu_rvalid, 1);
        chk("t1_rdata", rdata, 16'hBEEF);
        chk("t1_host_rvalid", host_rvalid, 0);
        cpu_req = 1'b0;
        tick();
        chk("t1_release_idle", {cpu_gnt, host_gnt}, 0);
        chk("t1_rvalid_once", cpu_rvalid, 0);

        // Tie right after reset: CPU first, then host on the next tie
        do_reset();
        cpu_req = 1'b1; host_req = 1'b1; cpu_addr = 8'h20; host_addr = 8'h30;
        tick();
        chk("t2_tie1_cpu", cpu_gnt, 1);
        chk("t2_tie1_host", host_gnt, 0);
        cpu_req = 1'b0; host_req = 1'b0;
        settle();
        chk("t2_noacc_addr", mem_addr, 0);
        tick();
        chk("t2_idle", {cpu_gnt, host_gnt}, 0);
        chk("t2_noacc_rvalid", cpu_rvalid, 0);
        cpu_req = 1'b1; host_req = 1'b1;
        tick();
        chk("t2_tie2_host", host_gnt, 1);
        chk("t2_tie2_cpu", cpu_gnt, 0);
        chk("t2_tie2_addr", mem_addr, 8'h30);
        cpu_req = 1'b0; host_req = 1'b0;
        tick();
        tick();

        // LOAD_A / LOAD_B: two back-to-back CPU reads, no grant gap
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 8'h20;
        tick();
        chk("t3_gnt_a", cpu_gnt, 1);
        chk("t3_addr_a", mem_addr, 8'h20);
        tick();
        cpu_addr = 8'h21;
        settle();
        chk("t3_gnt_b", cpu_gnt, 1);
        chk("t3_addr_b", mem_addr, 8'h21);
        chk("t3_rvalid_a", cpu_rvalid, 1);
        chk("t3_rdata_a", rdata, 16'hA520);
        tick();
        cpu_req = 1'b0;
        settle();
        chk("t3_rvalid_b", cpu_rvalid, 1);
        chk("t3_rdata_b", rdata, 16'hA521);
        tick();
        chk("t3_rvalid_end", cpu_rvalid, 0);

        // Starvation bound: host forced in after the 4th CPU access
        cpu_req = 1'b1; cpu_addr = 8'h40; host_wr = 1'b0; host_addr = 8'h50;
        tick();
        host_req = 1'b1;
        settle();
        chk("t4_acc1_cpu", cpu_gnt, 1);
        tick();
        chk("t4_acc2_cpu", cpu_gnt, 1);
        tick();
        chk("t4_acc3_cpu", cpu_gnt, 1);
        tick();
        chk("t4_acc4_cpu", cpu_gnt, 1);
        chk("t4_acc4_host", host_gnt, 0);
        tick();
        chk("t4_forced_host", host_gnt, 1);
        chk("t4_forced_cpu", cpu_gnt, 0);
        chk("t4_host_addr", mem_addr, 8'h50);
        chk("t4_cpu_last_rv", cpu_rvalid, 1);
        chk("t4_cpu_last_rd", rdata, 16'hA540);
        tick();
        chk("t4_host_rvalid", host_rvalid, 1);
        chk("t4_host_rdata", rdata, 16'hA550);
        host_req = 1'b0;
        tick();
        chk("t4_cpu_regain", cpu_gnt, 1);
        chk("t4_host_off", host_gnt, 0);
        cpu_req = 1'b0;
        tick();
        tick();

        // Host releases in the same cycle the CPU raises its request
        host_req = 1'b1; host_addr = 8'h60;
        tick();
        chk("t5_host_gnt", host_gnt, 1);
        host_req = 1'b0; cpu_req = 1'b1; cpu_addr = 8'h70;
        settle();
        chk("t5_no_access", mem_addr, 0);
        tick();
        chk("t5_cpu_next", cpu_gnt, 1);
        chk("t5_cpu_addr", mem_addr, 8'h70);
        chk("t5_host_norv", host_rvalid, 0);
        cpu_req = 1'b0;
        tick();
        tick();

        // Reset arriving right after a read access
        cpu_req = 1'b1; cpu_addr = 8'h80;
        tick();
        chk("t6_read_acc", mem_addr, 8'h80);
        tick();
        reset = 1'b1; cpu_req = 1'b0;
        settle();
        chk("t6_rvalid_killed", cpu_rvalid, 0);
        tick();
        reset = 1'b0;
        settle();
        chk("t6_outs_zero", {cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, mem_wr}, 0);
        chk("t6_addr_zero", mem_addr, 0);
        cpu_req = 1'b1; host_req = 1'b1;
        tick();
        chk("t6_tie_cpu", cpu_gnt, 1);
        chk("t6_tie_host", host_gnt, 0);
        cpu_req = 1'b0; host_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
